fpu_result_buffer: RTL and testbench

FPU_RESULT_BUFFER -- requirements
Module: fpu_result_buffer

---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_rb_fifo.sv | 69 ++++++
 rtl/fpu_result_buffer.sv | 120 ++++++++++++
 tb/tb_fpu_result_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared constants and the result-entry type for the fsqrt result buffer.
package fpu_pkg;

    localparam int FPU_RB_DEPTH     = 4;
    localparam int FPU_RB_TAG_W     = 5;
    localparam int FPU_RB_LATENCY   = 3;
    // Entry tags are stored at this width; narrower TAG_W values are zero-extended.
    localparam int FPU_RB_TAG_MAX_W = 16;

    typedef struct packed {
        logic [31:0]                 data;
        logic [FPU_RB_TAG_MAX_W-1:0] tag;
    } fpu_rb_entry_t;

endpackage

// File: rtl/fpu_rb_fifo.sv
// Synchronous result FIFO with a registered head entry and an occupancy count.
module fpu_rb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = FPU_RB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fpu_rb_entry_t          push_entry,
    input  logic                   pop,
    output fpu_rb_entry_t          head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fpu_rb_entry_t mem_q [DEPTH];
    fpu_rb_entry_t head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_next;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && (count_q != '0);
        do_push  = push && (!full || do_pop);
        rd_next  = rd_ptr_q + AW'(1);
        wr_ptr_d = do_push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_next : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        // Head register tracks mem[rd_ptr]; bypass the push when it becomes the head.
        head_d   = head_q;
        if (do_pop && (count_q > CW'(1))) begin
            head_d = mem_q[rd_next];
        end else if (do_push && ((count_q == '0) || do_pop)) begin
            head_d = push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/fpu_result_buffer.sv
// Credit-based result buffer behind a fixed-latency fsqrt pipeline.
// Optional protocol checking is enabled with FPU_RESULT_BUFFER_ERRCHK_EN.
module fpu_result_buffer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = FPU_RB_DEPTH,
    parameter int TAG_W   = FPU_RB_TAG_W,
    parameter int LATENCY = FPU_RB_LATENCY
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [TAG_W-1:0]       issue_tag,
    output logic                   issue_ready,
    input  logic                   fsqrt_valid,
    input  logic [31:0]            fsqrt_y,
    output logic                   wb_valid,
    output logic [31:0]            wb_data,
    output logic [TAG_W-1:0]       wb_tag,
    input  logic                   wb_ready,
    output logic [$clog2(DEPTH):0] credits_used,
    output logic                   err
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_tag_q [LATENCY];
    logic [TAG_W-1:0]   pipe_tag_d [LATENCY];
    logic [CW-1:0]      credits_q, credits_d;
    logic               accept;
    logic               pop;
    logic               exit_vld;
    logic [TAG_W-1:0]   exit_tag;
    logic               fifo_push;
    fpu_rb_entry_t      fifo_entry;
    fpu_rb_entry_t      fifo_head;
    logic [CW-1:0]      fifo_count;

    // Derived from the credit register alone so issue_ready has no input path.
    assign issue_ready = (credits_q < CW'(DEPTH));
    assign accept      = issue_valid && issue_ready;
    assign exit_vld    = pipe_vld_q[LATENCY-1];
    assign exit_tag    = pipe_tag_q[LATENCY-1];

    always_comb begin
        pipe_vld_d[0] = accept;
        pipe_tag_d[0] = accept ? issue_tag : pipe_tag_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        pipe_tag_q <= pipe_tag_d;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            credits_q  <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            credits_q  <= credits_d;
        end
    end

    // A result without a matching tag has no credit behind it, so it is dropped.
    always_comb begin
        fifo_push       = fsqrt_valid && exit_vld;
        fifo_entry      = '0;
        fifo_entry.data = fsqrt_y;
        fifo_entry.tag  = FPU_RB_TAG_MAX_W'(exit_tag);
    end

    fpu_rb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (sys_clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (fifo_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign wb_valid = (fifo_count != '0);
    assign wb_data  = fifo_head.data;
    assign wb_tag   = TAG_W'(fifo_head.tag);
    assign pop      = wb_valid && wb_ready;

    always_comb begin
        credits_d = credits_q + CW'(accept) - CW'(pop);
    end

    assign credits_used = credits_q;

`ifdef FPU_RESULT_BUFFER_ERRCHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (fsqrt_valid != exit_vld) || (issue_valid && !issue_ready);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Randomised scoreboard bench for fpu_result_buffer with a behavioural fsqrt stand-in.
module tb_fpu_result_buffer;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 5;
    localparam int LATENCY = 3;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             sys_clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic             fsqrt_valid;
    logic [31:0]      fsqrt_y;
    logic             wb_valid;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_ready;
    logic [CW-1:0]    credits_used;
    logic             err;

    fpu_result_buffer #(
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W),
        .LATENCY (LATENCY)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_tag    (issue_tag),
        .issue_ready  (issue_ready),
        .fsqrt_valid  (fsqrt_valid),
        .fsqrt_y      (fsqrt_y),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_tag       (wb_tag),
        .wb_ready     (wb_ready),
        .credits_used (credits_used),
        .err          (err)
    );

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model state ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc     = 0;
    logic [TAG_W+31:0] exp_q[$];
    logic [TAG_W-1:0] flight_q[$];
    int               fire_q[$];
    int               model_credits = 0;
    int               n_accepted = 0;
    int               n_popped   = 0;
    bit               pending_pop = 0;
    bit               exp_err     = 0;
    bit               unsol_req   = 0;
    bit               unsol_fired = 0;
    bit               use_fixed_y = 0;
    logic [31:0]      fixed_y = 32'h0;
    bit               mon_en = 0;
    bit               m_rdy, m_acc;
    logic [TAG_W+31:0] e;
    int               c0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        flight_q.delete();
        fire_q.delete();
        model_credits = 0;
        pending_pop   = 0;
        exp_err       = 0;
        unsol_req     = 0;
        unsol_fired   = 0;
    endtask

    // Credit/tag model: advances on each edge from inputs only.
    initial forever begin
        @(posedge sys_clk);
        if (!rst) begin
            m_rdy = (model_credits < DEPTH);
            m_acc = issue_valid && m_rdy;
`ifdef FPU_RESULT_BUFFER_ERRCHK_EN
            if ((issue_valid && !m_rdy) || unsol_fired) exp_err = 1;
`endif
            unsol_fired = 0;
            if (m_acc) begin
                flight_q.push_back(issue_tag);
                fire_q.push_back(cyc + LATENCY);
                n_accepted++;
            end
            model_credits = model_credits + int'(m_acc) - int'(pending_pop);
            pending_pop = 0;
        end
        cyc++;
    end

    // fsqrt stand-in: answers each accepted op exactly LATENCY cycles after issue.
    initial begin
        fsqrt_valid = 1'b0;
        fsqrt_y     = 32'h0;
        forever begin
            @(posedge sys_clk);
            #2;
            fsqrt_valid = 1'b0;
            if (!rst && fire_q.size() > 0 && fire_q[0] == cyc) begin
                void'(fire_q.pop_front());
                fsqrt_y     = use_fixed_y ? fixed_y : $urandom;
                fsqrt_valid = 1'b1;
                exp_q.push_back({fsqrt_y, flight_q.pop_front()});
            end else if (!rst && unsol_req) begin
                fsqrt_y     = $urandom;
                fsqrt_valid = 1'b1;
                unsol_req   = 0;
                unsol_fired = 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge sys_clk);
        if (!rst && mon_en) begin
            check("credits_used", 64'(credits_used), 64'(model_credits));
            check("issue_ready", 64'(issue_ready), 64'(model_credits < DEPTH));
            check("err", 64'(err), 64'(exp_err));
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL wb_spurious: got wb_valid=1 tag=%0d, expected no result (cycle %0d)", wb_tag, cyc);
                end else begin
                    e = exp_q[0];
                    check("wb_data", 64'(wb_data), 64'(e[TAG_W+31:TAG_W]));
                    check("wb_tag", 64'(wb_tag), 64'(e[TAG_W-1:0]));
                    if (wb_ready) begin
                        void'(exp_q.pop_front());
                        pending_pop = 1;
                        n_popped++;
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input bit iv, input logic [TAG_W-1:0] tag, input bit rdy);
        @(posedge sys_clk);
        #1;
        issue_valid = iv;
        issue_tag   = tag;
        wb_ready    = rdy;
    endtask

    task automatic reset_all();
        rst         = 1'b1;
        issue_valid = 1'b0;
        wb_ready    = 1'b0;
        clear_model();
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_issue_ready", 64'(issue_ready), 64'(1));
        check("rst_wb_valid", 64'(wb_valid), 64'(0));
        check("rst_wb_data", 64'(wb_data), 64'(0));
        check("rst_wb_tag", 64'(wb_tag), 64'(0));
        check("rst_credits", 64'(credits_used), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || fire_q.size() != 0 || wb_valid) && k < 200) begin
            tick(1'b0, '0, 1'b1);
            k++;
        end
        check(name, 64'(k < 200), 64'(1));
        tick(1'b0, '0, 1'b0);
        check("drain_credits", 64'(credits_used), 64'(0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_tag   = '0;
        wb_ready    = 1'b0;
        reset_all();
        mon_en = 1;

        // Single op: result presented LATENCY+1 cycles after issue.
        use_fixed_y = 1;
        fixed_y     = 32'h4000_0000;
        tick(1'b1, TAG_W'(5), 1'b0);
        c0 = cyc;
        repeat (LATENCY) tick(1'b0, '0, 1'b0);
        check("single_not_early", 64'(wb_valid), 64'(0));
        tick(1'b0, '0, 1'b1);
        check("single_latency", 64'(cyc - c0), 64'(LATENCY + 1));
        check("single_wb_valid", 64'(wb_valid), 64'(1));
        check("single_wb_data", 64'(wb_data), 64'(32'h4000_0000));
        check("single_wb_tag", 64'(wb_tag), 64'(5));
        check("single_credits_1", 64'(credits_used), 64'(1));
        tick(1'b0, '0, 1'b0);
        check("single_credits_0", 64'(credits_used), 64'(0));
        check("single_wb_empty", 64'(wb_valid), 64'(0));
        use_fixed_y = 0;

        // Back-to-back fill to DEPTH; a fifth request must be ignored.
        for (int i = 1; i <= 4; i++) tick(1'b1, TAG_W'(i), 1'b0);
        tick(1'b1, TAG_W'(9), 1'b0);
        check("b2b_ready_low", 64'(issue_ready), 64'(0));
        check("b2b_credits_full", 64'(credits_used), 64'(DEPTH));
        repeat (LATENCY + 2) tick(1'b0, '0, 1'b0);
        check("b2b_credits_held", 64'(credits_used), 64'(DEPTH));

        // Backpressure: head holds while writeback stalls.
        repeat (6) begin
            tick(1'b0, '0, 1'b0);
            check("bp_head_tag", 64'(wb_tag), 64'(1));
        end

        // Pop while full with issue requested, then simultaneous pop and accepted issue.
        tick(1'b1, TAG_W'(10), 1'b1);
        check("simul_full_credits", 64'(credits_used), 64'(DEPTH));
        check("simul_full_ready", 64'(issue_ready), 64'(0));
        tick(1'b1, TAG_W'(11), 1'b1);
        check("simul_after_pop", 64'(credits_used), 64'(DEPTH - 1));
        tick(1'b0, '0, 1'b0);
        check("simul_unchanged", 64'(credits_used), 64'(DEPTH - 1));
        drain("drain_directed");

        // Random traffic: mostly-ready then mostly-stalled writeback.
        repeat (600) tick(1'($urandom_range(0, 1)), TAG_W'($urandom), $urandom_range(0, 3) != 0);
        drain("drain_random_a");
        repeat (300) tick($urandom_range(0, 2) != 0, TAG_W'($urandom), $urandom_range(0, 3) == 0);
        drain("drain_random_b");
        check("no_result_lost", 64'(n_popped), 64'(n_accepted));

        // Asynchronous reset with a stored result and three ops in flight.
        tick(1'b1, TAG_W'(3), 1'b0);
        repeat (LATENCY + 1) tick(1'b0, '0, 1'b0);
        check("pre_rst_wb_valid", 64'(wb_valid), 64'(1));
        tick(1'b1, TAG_W'(4), 1'b0);
        tick(1'b1, TAG_W'(5), 1'b0);
        tick(1'b1, TAG_W'(6), 1'b0);
        tick(1'b0, '0, 1'b0);
        mon_en = 0;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check("arst_wb_valid", 64'(wb_valid), 64'(0));
        check("arst_wb_data", 64'(wb_data), 64'(0));
        check("arst_wb_tag", 64'(wb_tag), 64'(0));
        check("arst_credits", 64'(credits_used), 64'(0));
        check("arst_issue_ready", 64'(issue_ready), 64'(1));
        check("arst_err", 64'(err), 64'(0));
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        mon_en = 1;
        repeat (LATENCY + 2) tick(1'b0, '0, 1'b1);
        check("post_rst_issue_ready", 64'(issue_ready), 64'(1));
        check("post_rst_wb_valid", 64'(wb_valid), 64'(0));

        // Unsolicited fsqrt result.
        tick(1'b0, '0, 1'b0);
        unsol_req = 1;
        check("unsol_err_before", 64'(err), 64'(0));
        tick(1'b0, '0, 1'b0);
`ifdef FPU_RESULT_BUFFER_ERRCHK_EN
        check("unsol_err_set", 64'(err), 64'(1));
        repeat (4) tick(1'b0, '0, 1'b1);
        check("unsol_err_held", 64'(err), 64'(1));
`else
        check("unsol_err_tied", 64'(err), 64'(0));
        repeat (4) tick(1'b0, '0, 1'b1);
        check("unsol_err_still_0", 64'(err), 64'(0));
`endif
        check("unsol_no_entry", 64'(wb_valid), 64'(0));
        mon_en = 0;
        reset_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
